// File: rtl/job_dispatch_queue_pkg.sv
// Shared constants and FSM state type for the job dispatch queue.
// Field offsets follow the NVMe command layout (CDW12 host, CDW13 plane).
package job_dispatch_queue_pkg;

  localparam int unsigned DEFAULT_MAX_HOST_NUMBER  = 8;
  localparam int unsigned DEFAULT_MAX_PLANE_NUMBER = 16;
  localparam int unsigned NO_OF_TAG                = 64;
  localparam int unsigned CDW12_OFFSET             = 64;
  localparam int unsigned CDW13_OFFSET             = 96;
  localparam int unsigned BCAST_BIT                = 127;
  localparam int unsigned NO_OF_STATES             = 3;

  typedef enum logic [NO_OF_STATES-1:0] {
    IDLE   = 3'b001,
    DECODE = 3'b010,
    ISSUE  = 3'b100
  } dispatch_state_e;

endpackage

// File: rtl/job_fifo.sv
// Synchronous FIFO with occupancy count; push is ignored when full, pop when empty.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module job_fifo #(
  parameter  int unsigned WIDTH = 128,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/job_dispatch_queue.sv
// Buffers command info words, decodes host/plane/metadata and dispatches each job
// to one plane channel (plane mod NUM_CHANNELS) or to all channels on broadcast.
module job_dispatch_queue
  import job_dispatch_queue_pkg::*;
#(
  parameter  int unsigned MAX_HOST_NUMBER       = DEFAULT_MAX_HOST_NUMBER,
  parameter  int unsigned MAX_PLANE_NUMBER      = DEFAULT_MAX_PLANE_NUMBER,
  parameter  int unsigned INFO_DATA_BIT_WIDTH   = 128,
  parameter  int unsigned NUM_CHANNELS          = 2,
  parameter  int unsigned FIFO_DEPTH            = 4,
  parameter  int unsigned HOST_ID_START_OFFSET  = CDW12_OFFSET,
  parameter  int unsigned PLANE_ID_START_OFFSET = CDW13_OFFSET,
  localparam int unsigned HOST_ID_BIT_WIDTH     = $clog2(MAX_HOST_NUMBER),
  localparam int unsigned PLANE_ID_BIT_WIDTH    = $clog2(MAX_PLANE_NUMBER),
  localparam int unsigned CH_BIT_WIDTH          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int unsigned META_DATA_BIT_WIDTH   = INFO_DATA_BIT_WIDTH - HOST_ID_BIT_WIDTH - 1,
  localparam int unsigned CNT_W                 = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst_n,
  input  logic [INFO_DATA_BIT_WIDTH-1:0]              i_info,
  input  logic                                        i_info_valid,
  output logic                                        o_info_ready,
  output logic [NUM_CHANNELS*HOST_ID_BIT_WIDTH-1:0]   o_host_id,
  output logic [NUM_CHANNELS*PLANE_ID_BIT_WIDTH-1:0]  o_plane_id,
  output logic [NUM_CHANNELS*META_DATA_BIT_WIDTH-1:0] o_meta_data,
  output logic [NUM_CHANNELS-1:0]                     o_valid,
  input  logic [NUM_CHANNELS-1:0]                     i_ready,
  output logic [CNT_W-1:0]                            o_fifo_count,
  output logic                                        o_busy
);

  dispatch_state_e state_q, state_d;

  logic [INFO_DATA_BIT_WIDTH-1:0] fifo_rd_data;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic                           fifo_pop;

  logic [INFO_DATA_BIT_WIDTH-1:0] job_q;
  logic [NUM_CHANNELS-1:0]        pending_q;

  logic [HOST_ID_BIT_WIDTH-1:0]   dec_host;
  logic [PLANE_ID_BIT_WIDTH-1:0]  dec_plane;
  logic [META_DATA_BIT_WIDTH-1:0] dec_meta;
  logic [CH_BIT_WIDTH-1:0]        dec_ch;
  logic                           dec_bcast;
  logic [NUM_CHANNELS-1:0]        dec_mask;

  job_fifo #(
    .WIDTH (INFO_DATA_BIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (i_info_valid & o_info_ready),
    .wr_data (i_info),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_fifo_count)
  );

  assign o_info_ready = ~fifo_full;
  assign o_busy       = (state_q != IDLE) | ~fifo_empty;
  assign o_valid      = pending_q;

  assign dec_host  = job_q[HOST_ID_START_OFFSET +: HOST_ID_BIT_WIDTH];
  assign dec_plane = job_q[PLANE_ID_START_OFFSET +: PLANE_ID_BIT_WIDTH];
  assign dec_meta  = {job_q[INFO_DATA_BIT_WIDTH-2 : HOST_ID_START_OFFSET+HOST_ID_BIT_WIDTH],
                      job_q[HOST_ID_START_OFFSET-1 : 0]};
  assign dec_bcast = job_q[INFO_DATA_BIT_WIDTH-1];
  assign dec_ch    = dec_plane[CH_BIT_WIDTH-1:0];

  always_comb begin
    dec_mask = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      dec_mask[c] = dec_bcast | (NUM_CHANNELS == 1) | (dec_ch == CH_BIT_WIDTH'(c));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ISSUE leaves only once pending has been observed empty, so a retired job
  // is followed by the empty-ISSUE cycle and the DECODE cycle before the next.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: state_d = ISSUE;
      ISSUE: begin
        if (pending_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = DECODE;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      job_q       <= '0;
      pending_q   <= '0;
      o_host_id   <= '0;
      o_plane_id  <= '0;
      o_meta_data <= '0;
    end else begin
      if (fifo_pop) job_q <= fifo_rd_data;
      if (state_q == DECODE) begin
        pending_q <= dec_mask;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
          if (dec_mask[c]) begin
            o_host_id[c*HOST_ID_BIT_WIDTH +: HOST_ID_BIT_WIDTH]       <= dec_host;
            o_plane_id[c*PLANE_ID_BIT_WIDTH +: PLANE_ID_BIT_WIDTH]    <= dec_plane;
            o_meta_data[c*META_DATA_BIT_WIDTH +: META_DATA_BIT_WIDTH] <= dec_meta;
          end
        end
      end else if (state_q == ISSUE) begin
        pending_q <= pending_q & ~i_ready;
      end
    end
  end

endmodule

// File: tb/tb_job_dispatch_queue.sv
// Directed vector table plus handwritten sequences for job_dispatch_queue,
// with a per-channel scoreboard checking every accepted output handshake.
module tb_job_dispatch_queue;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b1;
  logic [127:0]   i_info = '0;
  logic           i_info_valid = 1'b0;
  logic           o_info_ready;
  logic [5:0]     o_host_id;
  logic [7:0]     o_plane_id;
  logic [247:0]   o_meta_data;
  logic [1:0]     o_valid;
  logic [1:0]     i_ready = '0;
  logic [2:0]     o_fifo_count;
  logic           o_busy;

  job_dispatch_queue #(
    .NUM_CHANNELS (2),
    .FIFO_DEPTH   (4)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_info       (i_info),
    .i_info_valid (i_info_valid),
    .o_info_ready (o_info_ready),
    .o_host_id    (o_host_id),
    .o_plane_id   (o_plane_id),
    .o_meta_data  (o_meta_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_fifo_count (o_fifo_count),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int hs0      = 0;
  int hs1      = 0;
  logic [127:0] q0[$];
  logic [127:0] q1[$];

  typedef struct {
    logic       bc;
    logic [2:0] host;
    logic [3:0] plane;
    logic [1:0] exp_valid;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [2:0] f_host(input logic [127:0] x);
    return x[66:64];
  endfunction
  function automatic logic [3:0] f_plane(input logic [127:0] x);
    return x[99:96];
  endfunction
  function automatic logic [123:0] f_meta(input logic [127:0] x);
    return {x[126:67], x[63:0]};
  endfunction
  function automatic logic [1:0] f_mask(input logic [127:0] x);
    if (x[127]) return 2'b11;
    return x[96] ? 2'b10 : 2'b01;
  endfunction
  function automatic logic [127:0] mk(input logic bc, input logic [2:0] h, input logic [3:0] p,
                                      input logic [127:0] rnd);
    logic [127:0] r;
    r = rnd;
    r[127] = bc;
    r[66:64] = h;
    r[99:96] = p;
    return r;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic sb_compare(input int c, input logic [127:0] e);
    check($sformatf("sb_ch%0d_host", c), o_host_id[c*3 +: 3], f_host(e));
    check($sformatf("sb_ch%0d_plane", c), o_plane_id[c*4 +: 4], f_plane(e));
    check($sformatf("sb_ch%0d_meta", c), o_meta_data[c*124 +: 124], f_meta(e));
  endtask

  // Called at a negedge with the next cycle's inputs already applied.
  task automatic tick();
    logic [127:0] e;
    logic [1:0]   m;
    if (o_valid[0] && i_ready[0]) begin
      if (q0.size() == 0) fail_now("sb_ch0_unexpected_job");
      else begin e = q0.pop_front(); sb_compare(0, e); end
      hs0++;
    end
    if (o_valid[1] && i_ready[1]) begin
      if (q1.size() == 0) fail_now("sb_ch1_unexpected_job");
      else begin e = q1.pop_front(); sb_compare(1, e); end
      hs1++;
    end
    if (i_info_valid && o_info_ready) begin
      m = f_mask(i_info);
      if (m[0]) q0.push_back(i_info);
      if (m[1]) q1.push_back(i_info);
      n_acc++;
    end
    @(negedge i_clk);
  endtask

  task automatic drain(input string name);
    i_info_valid = 1'b0;
    i_ready = 2'b11;
    for (int k = 0; k < 200 && (q0.size() != 0 || q1.size() != 0 || o_busy); k++) tick();
    check({name, "_q0_left"}, q0.size(), 0);
    check({name, "_q1_left"}, q1.size(), 0);
    check({name, "_busy"}, o_busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t         vecs[6];
    logic [2:0]   eh[2];
    logic [3:0]   ep[2];
    logic [123:0] em[2];
    logic [127:0] info;
    logic [5:0]   saved_host;
    logic [247:0] saved_meta;
    int           h0, h1, acc0, cyc;

    vecs[0] = '{1'b0, 3'd3, 4'd5,  2'b10};
    vecs[1] = '{1'b0, 3'd6, 4'd4,  2'b01};
    vecs[2] = '{1'b0, 3'd0, 4'd15, 2'b10};
    vecs[3] = '{1'b0, 3'd7, 4'd0,  2'b01};
    vecs[4] = '{1'b1, 3'd3, 4'd5,  2'b11};
    vecs[5] = '{1'b0, 3'd1, 4'd2,  2'b01};
    for (int c = 0; c < 2; c++) begin eh[c] = '0; ep[c] = '0; em[c] = '0; end

    // reset state
    #1 i_rst_n = 1'b0;
    #10;
    check("rst_valid", o_valid, 2'b00);
    check("rst_count", o_fifo_count, 0);
    check("rst_ready", o_info_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_host", o_host_id, 0);
    check("rst_meta", o_meta_data, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();

    // table: unicast / broadcast routing, latency, retention of non-target slices
    for (int v = 0; v < 6; v++) begin
      info = mk(vecs[v].bc, vecs[v].host, vecs[v].plane, rnd128());
      i_ready = 2'b11;
      i_info = info;
      i_info_valid = 1'b1;
      tick();
      i_info_valid = 1'b0;
      check($sformatf("v%0d_valid_t1", v), o_valid, 2'b00);
      tick();
      check($sformatf("v%0d_valid_t2", v), o_valid, 2'b00);
      tick();
      check($sformatf("v%0d_valid_t3", v), o_valid, vecs[v].exp_valid);
      for (int c = 0; c < 2; c++) begin
        if (vecs[v].exp_valid[c]) begin
          eh[c] = vecs[v].host;
          ep[c] = vecs[v].plane;
          em[c] = f_meta(info);
        end
      end
      check($sformatf("v%0d_host", v), o_host_id, {eh[1], eh[0]});
      check($sformatf("v%0d_plane", v), o_plane_id, {ep[1], ep[0]});
      check($sformatf("v%0d_meta", v), o_meta_data, {em[1], em[0]});
      tick();
      check($sformatf("v%0d_valid_t4", v), o_valid, 2'b00);
      tick();
      tick();
      check($sformatf("v%0d_busy", v), o_busy, 0);
    end

    // broadcast with staggered accept
    h0 = hs0; h1 = hs1;
    i_ready = 2'b01;
    i_info = mk(1'b1, 3'd3, 4'd5, rnd128());
    i_info_valid = 1'b1;
    tick();
    i_info_valid = 1'b0;
    tick();
    tick();
    check("bc_valid_both", o_valid, 2'b11);
    saved_host = o_host_id;
    saved_meta = o_meta_data;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("bc_hold%0d_valid", k), o_valid, 2'b10);
      check($sformatf("bc_hold%0d_host", k), o_host_id, saved_host);
      check($sformatf("bc_hold%0d_meta", k), o_meta_data, saved_meta);
    end
    i_ready = 2'b11;
    tick();
    check("bc_valid_done", o_valid, 2'b00);
    tick();
    tick();
    check("bc_busy", o_busy, 0);
    check("bc_ch0_accepts", hs0 - h0, 1);
    check("bc_ch1_accepts", hs1 - h1, 1);
    check("bc_q0_left", q0.size(), 0);
    check("bc_q1_left", q1.size(), 0);

    // backpressure fill
    i_ready = 2'b00;
    acc0 = n_acc;
    for (int i = 0; i < 6; i++) begin
      i_info = mk(1'b0, 3'(i), 4'(i), rnd128());
      i_info_valid = 1'b1;
      check($sformatf("bp_ready%0d", i), o_info_ready, (i < 5) ? 1 : 0);
      tick();
    end
    i_info_valid = 1'b0;
    check("bp_count_full", o_fifo_count, 4);
    check("bp_ready_full", o_info_ready, 0);
    check("bp_accepted", n_acc - acc0, 5);
    h0 = hs0; h1 = hs1;
    drain("bp_drain");
    check("bp_retired", (hs0 - h0) + (hs1 - h1), 5);

    // push and pop in the same cycle at count=2
    i_ready = 2'b00;
    i_info = mk(1'b0, 3'd2, 4'd2, rnd128());
    i_info_valid = 1'b1;
    tick();
    i_info = mk(1'b0, 3'd4, 4'd7, rnd128());
    tick();
    i_info = mk(1'b0, 3'd5, 4'd8, rnd128());
    tick();
    i_info_valid = 1'b0;
    check("pp_count_pre", o_fifo_count, 2);
    check("pp_valid_pre", o_valid, 2'b01);
    i_ready = 2'b11;
    tick();
    check("pp_valid_gap", o_valid, 2'b00);
    check("pp_count_gap", o_fifo_count, 2);
    i_info = mk(1'b0, 3'd6, 4'd9, rnd128());
    i_info_valid = 1'b1;
    tick();
    i_info_valid = 1'b0;
    check("pp_count_same", o_fifo_count, 2);
    drain("pp_drain");

    // reset during ISSUE
    i_ready = 2'b00;
    for (int i = 0; i < 4; i++) begin
      i_info = mk(1'b0, 3'(i), 4'(2 * i), rnd128());
      i_info_valid = 1'b1;
      tick();
    end
    i_info_valid = 1'b0;
    check("rm_valid_pre", o_valid, 2'b01);
    check("rm_count_pre", o_fifo_count, 3);
    #2 i_rst_n = 1'b0;
    #1;
    check("rm_valid", o_valid, 2'b00);
    check("rm_count", o_fifo_count, 0);
    check("rm_ready", o_info_ready, 1);
    check("rm_busy", o_busy, 0);
    check("rm_host", o_host_id, 0);
    q0.delete();
    q1.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 2'b11;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("rm_no_stale%0d", k), o_valid, 2'b00);
    end

    // random jobs with random consumer readiness
    acc0 = n_acc;
    cyc = 0;
    while ((n_acc - acc0 < 1000) && cyc < 30000) begin
      i_info = rnd128();
      i_info_valid = ($urandom_range(0, 3) != 0);
      i_ready = 2'($urandom_range(0, 3));
      tick();
      cyc++;
    end
    if (n_acc - acc0 < 1000) fail_now("rnd_cycle_budget_expired");
    drain("rnd_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/job_dispatch_queue.md
Name: job_dispatch_queue

Overview:
Parametrised successor to the single-shot job decoder. Accepts 128-bit NVMe-style command info words through a valid/ready handshake and buffers them in a small FIFO. It decodes host ID, plane ID and metadata, then dispatches each job to one of NUM_CHANNELS plane-channel outputs, or to all of them in broadcast mode. Each output channel has its own valid/ready handshake. Sits between the command fetch path and the per-plane schedulers.

Parameters:
MAX_HOST_NUMBER, `MAX_HOST_NUMBER (8), number of hosts
MAX_PLANE_NUMBER, `MAX_PLANE_NUMBER (16), number of planes
INFO_DATA_BIT_WIDTH, 128, command info width
NUM_CHANNELS, 2, output channels; power of 2, ≤ MAX_PLANE_NUMBER
FIFO_DEPTH, 4, input buffer entries; power of 2, ≥2
HOST_ID_START_OFFSET, 64, host ID LSB (CDW12)
PLANE_ID_START_OFFSET, 96, plane ID LSB (CDW13)
HOST_ID_BIT_WIDTH, $clog2(MAX_HOST_NUMBER), derived
PLANE_ID_BIT_WIDTH, $clog2(MAX_PLANE_NUMBER), derived
CH_BIT_WIDTH, max(1,$clog2(NUM_CHANNELS)), derived
META_DATA_BIT_WIDTH, INFO_DATA_BIT_WIDTH-HOST_ID_BIT_WIDTH-1, derived

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_info  in  INFO_DATA_BIT_WIDTH  command info word
i_info_valid  in  1  info word valid
o_info_ready  out  1  FIFO can accept
o_host_id  out  NUM_CHANNELS*HOST_ID_BIT_WIDTH  per-channel host ID, channel c at slice c
o_plane_id  out  NUM_CHANNELS*PLANE_ID_BIT_WIDTH  per-channel plane ID
o_meta_data  out  NUM_CHANNELS*META_DATA_BIT_WIDTH  per-channel metadata
o_valid  out  NUM_CHANNELS  per-channel job valid
i_ready  in  NUM_CHANNELS  per-channel consumer ready
o_fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
o_busy  out  1  dispatcher not in IDLE, or FIFO non-empty

Behaviour:
- Reset: i_rst_n is asynchronous and active-low; i_clk is the clock. In reset, o_valid=0, all data outputs=0, o_fifo_count=0, o_info_ready=1, o_busy=0, FSM=IDLE. Reset mid-operation discards all queued and in-flight jobs.
- FIFO push occurs when i_info_valid & o_info_ready. o_info_ready = !full, derived from registered count only. A pop in the same cycle does not open space while the FIFO is full.
- Simultaneous push and pop on a non-full FIFO leaves the count unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
- Field decode:
  - host = info[HOST_ID_START_OFFSET +: HOST_ID_BIT_WIDTH]
  - plane = info[PLANE_ID_START_OFFSET +: PLANE_ID_BIT_WIDTH]
  - meta = {info[126 : HOST_ID_START_OFFSET+HOST_ID_BIT_WIDTH], info[HOST_ID_START_OFFSET-1 : 0]}
  - bcast = info[127]
- Target mask:
  - bcast=1: all ones.
  - Otherwise one-hot at channel plane[CH_BIT_WIDTH-1:0] (plane mod NUM_CHANNELS).
  - NUM_CHANNELS=1: channel 0 always.
- FSM, one-hot encoded (registered outputs only, no latches):
  - IDLE: if FIFO non-empty, pop head into job register, go to DECODE.
  - DECODE: compute fields and target mask, register them. Go to ISSUE.
  - ISSUE: drive o_valid = pending mask. Data is written to all target slices; non-target slices keep their previous value. For each channel c with o_valid[c] & i_ready[c], clear pending[c] in the next cycle. When the last pending bit clears: if FIFO non-empty, pop and go to DECODE; otherwise go to IDLE.
- Latency: a push at cycle T with an empty FIFO and idle FSM gives o_valid at T+3. Back-to-back dispatch costs 2 idle output cycles per job.
- Per-channel output data and valid stay stable while o_valid[c] & !i_ready[c]. A broadcast job completes only after every channel has accepted; channels may accept in different cycles.
- i_ready on a channel whose o_valid is 0 is ignored.
- Outputs drive no X: all output registers are assigned in every state.

Decomposition:
- defines.vh holds MAX_HOST_NUMBER, MAX_PLANE_NUMBER, NO_OF_TAG, the CDW12/CDW13 offset constants, BCAST bit index 127, and the FSM state indices (IDLE=0, DECODE=1, ISSUE=2, NO_OF_STATES=3).
- Sub-module job_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count. It is instantiated once for the input buffer.

Test Plan:
1. Unicast routing: info host bits[66:64]=3, plane bits[99:96]=5, bit127=0, i_ready=2'b11 -> at T+3 o_valid=2'b10, host slice1=3, plane slice1=5, o_valid[0] stays 0; next cycle o_valid=0.
2. Broadcast with staggered accept: same info with bit127=1; i_ready[0]=1 at once, i_ready[1] raised 4 cycles later -> o_valid=2'b11, then 2'b10 held stable for 4 cycles, then 0; exactly one job retired.
3. Backpressure fill: i_ready=0, push 6 words back-to-back -> 5 accepted (1 in dispatcher + 4 in FIFO), o_fifo_count=4, o_info_ready=0 from the 5th accept onward. Raising i_ready drains all 5 in push order.
4. Push/pop same cycle: with the FIFO at count=2 and a dispatcher pop in the same cycle as a push -> count stays 2, no data loss or reorder, checked against a scoreboard.
5. Reset mid-ISSUE: assert i_rst_n=0 while o_valid=2'b01 and count=3 -> o_valid=0, count=0, o_info_ready=1 asynchronously; after release, no stale job is issued.
6. Metadata check: random info words -> each o_meta_data slice equals {info[126:67], info[63:0]} (HOST_ID_BIT_WIDTH=3), compared by a scoreboard over 1000 jobs with random i_ready.
